// File: rtl/range_gen.sv
// range_gen: forward model of the trilateration datapath.
// Latches a target (xT, yT) and two anchors B and C, computes the Euclidean
// distance to each anchor with one shared restoring square-root engine, and
// emits {x, y, r} anchor descriptors in the layout used by `intersections`.
module range_gen #(
  parameter int N = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic signed [N-1:0] xT,
  input  logic signed [N-1:0] yT,
  input  logic signed [N-1:0] xB_in,
  input  logic signed [N-1:0] yB_in,
  input  logic signed [N-1:0] xC_in,
  input  logic signed [N-1:0] yC_in,
  output logic [3*N:0]        g_init,
  output logic [3*N:0]        e_init,
  output logic                busy,
  output logic                valid,
  output logic                sat
);

  // Radicand, root and partial-remainder widths of the square-root engine.
  // The remainder never exceeds 2*root, so N+4 bits are sufficient.
  localparam int RW = 2*N + 4;
  localparam int QW = N + 2;
  localparam int MW = N + 4;
  localparam int CW = $clog2(QW);

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ROOT_B,
    ROOT_C,
    DONE
  } state_t;

  state_t               state;

  logic signed [N-1:0]  xt_q;
  logic signed [N-1:0]  yt_q;
  logic signed [N-1:0]  xb_q;
  logic signed [N-1:0]  yb_q;
  logic signed [N-1:0]  xc_q;
  logic signed [N-1:0]  yc_q;

  logic [RW-1:0]        dc2_q;
  logic [RW-1:0]        rad;
  logic [MW-1:0]        rem;
  logic [QW-1:0]        root;
  logic [CW-1:0]        cnt;
  logic [N:0]           rb_q;
  logic                 satb_q;

  logic [MW-1:0]        rem_nxt;
  logic [QW-1:0]        root_nxt;
  logic                 last_iter;

  // Squared distance between two points: differences on N+1 bits, squares on
  // 2N+2 bits, sum on 2N+3 bits, zero-extended to the radicand width.
  function automatic logic [RW-1:0] dist_sq(
    input logic signed [N-1:0] xa,
    input logic signed [N-1:0] ya,
    input logic signed [N-1:0] xb,
    input logic signed [N-1:0] yb
  );
    logic signed [N:0]     dx;
    logic signed [N:0]     dy;
    logic signed [2*N+1:0] ex;
    logic signed [2*N+1:0] ey;
    logic signed [2*N+1:0] sx;
    logic signed [2*N+1:0] sy;
    logic [2*N+2:0]        sum;
    dx  = {xa[N-1], xa} - {xb[N-1], xb};
    dy  = {ya[N-1], ya} - {yb[N-1], yb};
    ex  = {{(N+1){dx[N]}}, dx};
    ey  = {{(N+1){dy[N]}}, dy};
    sx  = ex * ex;
    sy  = ey * ey;
    sum = {1'b0, sx} + {1'b0, sy};
    return {1'b0, sum};
  endfunction

  // One restoring digit step: bring down two radicand bits, try subtracting
  // 4*root+1, keep the difference and shift in a 1 if it does not go negative.
  function automatic logic [MW+QW-1:0] sqrt_step(
    input logic [MW-1:0] r,
    input logic [QW-1:0] q,
    input logic [1:0]    d
  );
    logic [MW+1:0] acc;
    logic [MW+1:0] trial;
    logic [MW-1:0] rem_n;
    logic [QW-1:0] q_n;
    acc   = {r, d};
    trial = {{(MW-QW){1'b0}}, q, 2'b01};
    if (acc >= trial) begin
      rem_n = acc[MW-1:0] - trial[MW-1:0];
      q_n   = {q[QW-2:0], 1'b1};
    end else begin
      rem_n = acc[MW-1:0];
      q_n   = {q[QW-2:0], 1'b0};
    end
    return {rem_n, q_n};
  endfunction

  // Clamp a root to the largest value the N+1 bit range field carries.
  function automatic logic [N:0] sat_range(input logic [QW-1:0] q);
    if (|q[QW-1:N]) begin
      return {1'b0, {N{1'b1}}};
    end else begin
      return q[N:0];
    end
  endfunction

  function automatic logic is_sat(input logic [QW-1:0] q);
    return |q[QW-1:N];
  endfunction

  assign {rem_nxt, root_nxt} = sqrt_step(rem, root, rad[RW-1 -: 2]);
  assign last_iter           = (cnt == CW'(QW-1));

  // Job sequencer, shared square-root engine and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      xt_q   <= '0;
      yt_q   <= '0;
      xb_q   <= '0;
      yb_q   <= '0;
      xc_q   <= '0;
      yc_q   <= '0;
      dc2_q  <= '0;
      rad    <= '0;
      rem    <= '0;
      root   <= '0;
      cnt    <= '0;
      rb_q   <= '0;
      satb_q <= 1'b0;
      g_init <= '0;
      e_init <= '0;
      busy   <= 1'b0;
      valid  <= 1'b0;
      sat    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          valid <= 1'b0;
          if (start) begin
            xt_q  <= xT;
            yt_q  <= yT;
            xb_q  <= xB_in;
            yb_q  <= yB_in;
            xc_q  <= xC_in;
            yc_q  <= yC_in;
            busy  <= 1'b1;
            state <= PREP;
          end
        end

        PREP: begin
          dc2_q <= dist_sq(xt_q, yt_q, xc_q, yc_q);
          rad   <= dist_sq(xt_q, yt_q, xb_q, yb_q);
          rem   <= '0;
          root  <= '0;
          cnt   <= '0;
          state <= ROOT_B;
        end

        ROOT_B: begin
          if (last_iter) begin
            rb_q   <= sat_range(root_nxt);
            satb_q <= is_sat(root_nxt);
            rad    <= dc2_q;
            rem    <= '0;
            root   <= '0;
            cnt    <= '0;
            state  <= ROOT_C;
          end else begin
            rad  <= {rad[RW-3:0], 2'b00};
            rem  <= rem_nxt;
            root <= root_nxt;
            cnt  <= cnt + CW'(1);
          end
        end

        ROOT_C: begin
          if (last_iter) begin
            g_init <= {xb_q, yb_q, rb_q};
            e_init <= {xc_q, yc_q, sat_range(root_nxt)};
            sat    <= satb_q | is_sat(root_nxt);
            valid  <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end else begin
            rad  <= {rad[RW-3:0], 2'b00};
            rem  <= rem_nxt;
            root <= root_nxt;
            cnt  <= cnt + CW'(1);
          end
        end

        DONE: begin
          valid <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_range_gen.sv
// tb_range_gen: scoreboard bench for range_gen (N=8). Expected descriptors are
// computed from the geometry with integer arithmetic and queued per job; a
// monitor pops and compares on every valid pulse.
module tb_range_gen;

  localparam int N   = 8;
  localparam int LAT = 2*N + 5;
  localparam int PER = 2*N + 7;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic signed [N-1:0] xT, yT, xB_in, yB_in, xC_in, yC_in;
  logic [3*N:0]        g_init, e_init;
  logic                busy, valid, sat;

  range_gen #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .xT     (xT),
    .yT     (yT),
    .xB_in  (xB_in),
    .yB_in  (yB_in),
    .xC_in  (xC_in),
    .yC_in  (yC_in),
    .g_init (g_init),
    .e_init (e_init),
    .busy   (busy),
    .valid  (valid),
    .sat    (sat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3*N:0] g;
    logic [3*N:0] e;
    logic         s;
    int           acc;
  } exp_t;

  exp_t         sb[$];
  exp_t         mexp;
  int           n_vec = 0;
  int           n_err = 0;
  logic [3*N:0] held_g = '0;
  logic [3*N:0] held_e = '0;
  logic         held_s = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic int isqrt(input int d);
    int r = 0;
    while ((r + 1) * (r + 1) <= d) r++;
    return r;
  endfunction

  function automatic exp_t model(input int xt, input int yt, input int xb, input int yb,
                                 input int xc, input int yc, input int acc);
    exp_t m;
    int   rb, rc;
    rb    = isqrt((xt - xb) * (xt - xb) + (yt - yb) * (yt - yb));
    rc    = isqrt((xt - xc) * (xt - xc) + (yt - yc) * (yt - yc));
    m.s   = (rb > 255) || (rc > 255);
    if (rb > 255) rb = 255;
    if (rc > 255) rc = 255;
    m.g   = {8'(xb), 8'(yb), 9'(rb)};
    m.e   = {8'(xc), 8'(yc), 9'(rc)};
    m.acc = acc;
    return m;
  endfunction

  // Monitor: compare each valid pulse with the oldest queued job, otherwise
  // require the outputs to hold the last delivered result.
  always @(negedge clk) begin
    if (rst) begin
      held_g = '0;
      held_e = '0;
      held_s = 1'b0;
    end else if (valid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_valid: got valid=1, expected no pending job (cycle %0d)", cyc);
      end else begin
        mexp = sb.pop_front();
        chk("g_init", 32'(g_init), 32'(mexp.g));
        chk("e_init", 32'(e_init), 32'(mexp.e));
        chk("sat", 32'(sat), 32'(mexp.s));
        chk("latency", 32'(cyc - mexp.acc), 32'(LAT));
        held_g = mexp.g;
        held_e = mexp.e;
        held_s = mexp.s;
      end
    end else begin
      chk("hold_g", 32'(g_init), 32'(held_g));
      chk("hold_e", 32'(e_init), 32'(held_e));
      chk("hold_sat", 32'(sat), 32'(held_s));
    end
  end

  task automatic set_in(input int xt, input int yt, input int xb, input int yb,
                        input int xc, input int yc);
    xT    = 8'(xt);
    yT    = 8'(yt);
    xB_in = 8'(xb);
    yB_in = 8'(yb);
    xC_in = 8'(xc);
    yC_in = 8'(yc);
  endtask

  task automatic scramble();
    set_in($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
           $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
  endtask

  // Present one start pulse from IDLE; the job is accepted on the next edge.
  task automatic issue(input int xt, input int yt, input int xb, input int yb,
                       input int xc, input int yc, input bit want);
    int acc;
    @(posedge clk); #1;
    set_in(xt, yt, xb, yb, xc, yc);
    start = 1'b1;
    @(posedge clk); #1;
    acc   = cyc;
    start = 1'b0;
    if (want) sb.push_back(model(xt, yt, xb, yb, xc, yc, acc));
    chk("busy_run", 32'(busy), 32'd1);
    scramble();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 4 * PER; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: got %0d jobs pending, expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
    chk("busy_idle", 32'(busy), 32'd0);
    chk("valid_idle", 32'(valid), 32'd0);
  endtask

  function automatic int rcoord();
    case ($urandom_range(0, 7))
      0:       return -128;
      1:       return 127;
      default: return int'($urandom_range(0, 255)) - 128;
    endcase
  endfunction

  initial begin
    int acc0;
    rst   = 1'b1;
    start = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_g", 32'(g_init), 32'd0);
    chk("rst_e", 32'(e_init), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);
    rst = 1'b0;

    // Basic 3-4-5 job and a floor(sqrt 52) range.
    issue(3, 4, 0, 0, -3, 0, 1'b1);
    wait_idle();

    // Saturated B range, coincident C anchor.
    issue(127, 127, -128, -128, 127, 127, 1'b1);
    wait_idle();

    // A start pulse mid-job with different inputs is ignored.
    issue(3, 4, 0, 0, -3, 0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    set_in(0, 0, 50, -20, 17, 99);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();
    repeat (PER + 5) @(posedge clk);
    #1;
    chk("no_requeue", 32'(valid), 32'd0);

    // start held high: back-to-back jobs at the minimum period.
    @(posedge clk); #1;
    set_in(0, 10, 0, 0, 6, 2);
    start = 1'b1;
    @(posedge clk); #1;
    acc0 = cyc;
    for (int j = 0; j < 3; j++) sb.push_back(model(0, 10, 0, 0, 6, 2, acc0 + j * PER));
    repeat (2 * PER) @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();

    // Reset during ROOT_C aborts the job and clears everything at once.
    issue(3, 4, 0, 0, -3, 0, 1'b0);
    repeat (N + 6) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("abort_g", 32'(g_init), 32'd0);
    chk("abort_e", 32'(e_init), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(valid), 32'd0);
    chk("abort_sat", 32'(sat), 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    issue(3, 4, 0, 0, -3, 0, 1'b1);
    wait_idle();

    // Random sweep including extreme coordinates.
    for (int j = 0; j < 1000; j++) begin
      issue(rcoord(), rcoord(), rcoord(), rcoord(), rcoord(), rcoord(), 1'b1);
      wait_idle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish by cycle %0d, expected finish", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/range_gen.md
Name: range_gen

Overview:
- Forward model of the trilateration datapath: converts a target position (x, y) into the two anchor descriptors consumed by `intersections`.
- Computes the Euclidean distance from the target to anchors B and C using one shared iterative integer square root.
- Emits the packed {x, y, r} words in exactly the `g_init` / `e_init` layout that `intersections` accepts.
- Used as a stimulus/loop-back generator and as the range source for the simulated localisation front end.

Parameters:
- N, 8, coordinate width. Coordinates are signed N bits; range is signed N+1 bits (always non-negative).

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request a computation; sampled only in IDLE
- xT  input  N  target x, signed
- yT  input  N  target y, signed
- xB_in  input  N  anchor B x, signed
- yB_in  input  N  anchor B y, signed
- xC_in  input  N  anchor C x, signed
- yC_in  input  N  anchor C y, signed
- g_init  output  3N+1  {xB, yB, rB}: [3N:2N+1]=xB, [2N:N+1]=yB, [N:0]=rB
- e_init  output  3N+1  {xC, yC, rC}, same field layout
- busy  output  1  high in PREP, ROOT_B, ROOT_C
- valid  output  1  one-cycle pulse; g_init/e_init updated on the same edge
- sat  output  1  set if rB or rC saturated in the last completed job

Behaviour:
- Reset (async, while rst=1):
  - state=IDLE; g_init=0, e_init=0, busy=0, valid=0, sat=0.
  - Internal registers cleared.
  - Reset mid-job aborts the job with no partial output update.
- FSM states: IDLE, PREP, ROOT_B, ROOT_C, DONE.
- IDLE:
  - start=1 at edge k latches all six inputs and moves to PREP.
  - Inputs may change freely after edge k.
- PREP (edge k+1):
  - dB2 = (xT-xB)^2 + (yT-yB)^2 and dC2 likewise.
  - Differences are N+1 bits signed; squares are 2N+2 bits unsigned; sums are 2N+3 bits, zero-extended to a 2N+4 bit radicand.
  - Load the square-root engine with dB2; go to ROOT_B.
- Square-root engine:
  - Restoring digit-by-digit method, one result bit per edge, N+2 iterations, result = floor(sqrt(radicand)) on N+2 bits.
  - No divider or multiplier inside the loop.
- ROOT_B (edges k+2 .. k+N+3):
  - On the final iteration edge, store the root of dB2 and reload the engine with dC2.
  - Go to ROOT_C.
- ROOT_C (edges k+N+4 .. k+2N+5):
  - On the final iteration edge, write g_init = {latched xB, latched yB, rB} and e_init = {latched xC, latched yC, rC}.
  - Update sat; go to DONE.
- Saturation: if a root exceeds 2^N-1, the r field is 2^N-1 and sat=1. sat is set if either range saturated, otherwise cleared.
- DONE: valid=1 for exactly this cycle; next edge goes to IDLE.
- Latency: valid is high in the cycle after edge k+2N+5, i.e. 2N+5 edges after the accepting edge (21 for N=8).
- Repetition:
  - Minimum job period is 2N+7 cycles.
  - start is ignored in PREP, ROOT_B, ROOT_C and DONE; it is not queued.
- Output hold: g_init, e_init and sat hold their values between DONE updates and do not change during a job.
- Coincident anchors (anchor equal to target): radicand 0, r=0, no special case.
- Extreme inputs: no overflow for any input combination. The maximum radicand 2*(2^N-1)^2 fits in 2N+3 bits.

Test Plan (N=8):
1. Reset, then start at edge k with T=(3,4), B=(0,0), C=(-3,0) -> at edge k+21: g_init={8'h00,8'h00,9'd5}, e_init={8'hFD,8'h00,9'd7} (floor sqrt 52), valid one cycle, sat=0, busy low afterwards.
2. T=(127,127), B=(-128,-128), C=(127,127) -> rB=255 saturated (true root 360), rC=0, sat=1, e_init={8'h7F,8'h7F,9'd0}.
3. Start accepted with case-1 inputs; at cycle 5 pulse start with T=(0,0) and change all inputs -> result identical to case 1; no second valid until a new start in IDLE.
4. start held high continuously with T=(0,10), B=(0,0), C=(6,2) -> valid pulses every 23 cycles, rB=10, rC=10 (sqrt 100), outputs constant between pulses.
5. Assert rst during ROOT_C of a case-1 job -> outputs, busy and valid drop to 0 immediately. After release, a fresh case-1 start gives the correct result 21 edges later.
6. Random sweep of 1000 jobs vs. reference model floor(sqrt()) with saturation -> exact match on both r fields and sat, fixed 21-cycle latency each time.
